// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX arbiter: FSM state encoding and
// the watchdog timeout used when UART_TX_ARB_WDOG_EN is defined.
package uart_tx_arb_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    LOCKED    = 3'd4
  } state_t;

  localparam int WDOG_CYCLES = 4;
  localparam int WDOG_W      = $clog2(WDOG_CYCLES);
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit searching upward
// from last+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  int best_d;
  int d;

  // Each requester's distance past `last` in rotation order; the smallest wins.
  always_comb begin
    best_d = NREQ;
    d      = 0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - int'(last) - 1) % NREQ;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        idx    = IDX_W'(i);
      end
    end
    found  = (best_d < NREQ);
    onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      onehot[i] = found && (int'(idx) == i);
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ byte producers, with
// optional per-requester lock. Define UART_TX_ARB_WDOG_EN for the WAIT_BUSY watchdog.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        grant,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic                   err
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [NREQ-1:0]    win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [DATA_W-1:0]  win_data;
  logic [DATA_W-1:0]  own_data;
  logic               own_valid;
  logic               own_lock;
  logic               accept_idle;
  logic               accept_lock;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (req_valid),
    .last   (last),
    .onehot (win_oh),
    .idx    (win_idx),
    .found  (win_found)
  );

  // The owner is tracked by the one-hot grant, so no extra index register is kept.
  always_comb begin
    win_data  = '0;
    own_data  = '0;
    own_valid = |(req_valid & grant);
    own_lock  = |(req_lock & grant);
    for (int i = 0; i < NREQ; i++) begin
      if (int'(win_idx) == i) win_data = req_data[i*DATA_W +: DATA_W];
      if (grant[i])           own_data = req_data[i*DATA_W +: DATA_W];
    end
    accept_idle = (state == IDLE) && !tx_busy && win_found;
    accept_lock = (state == LOCKED) && own_valid;
    if (accept_idle)          req_ready = win_oh;
    else if (state == LOCKED) req_ready = grant & req_valid;
    else                      req_ready = '0;
  end

`ifdef UART_TX_ARB_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= IDX_W'(NREQ - 1);
      grant    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
`ifdef UART_TX_ARB_WDOG_EN
      err      <= 1'b0;
      wdog_cnt <= '0;
`endif
    end else begin
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_idle) begin
            tx_data  <= win_data;
            grant    <= win_oh;
            last     <= win_idx;
            tx_start <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
`ifdef UART_TX_ARB_WDOG_EN
          wdog_cnt <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end
`ifdef UART_TX_ARB_WDOG_EN
          else if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
            state <= IDLE;
            grant <= '0;
            err   <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
          end
`endif
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (own_lock) begin
              state <= LOCKED;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end
        end
        LOCKED: begin
          // Locked bytes keep `last` untouched so rotation resumes where it left off.
          if (accept_lock) begin
            tx_data  <= own_data;
            tx_start <= 1'b1;
            state    <= ISSUE;
          end else if (!own_lock) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
